// File: rtl/plot_framebuffer_reader_if.sv
// Plot-side and readback-side signals of the framebuffer reader, bundled as one port.
// Latency: none; wiring only.
// Backpressure: rd_ready from the master stalls the readback stream; plot strobes are never stalled.
interface plot_framebuffer_reader_if #(
  parameter int CW = 3
);
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;
  logic          start;
  logic          done;
  logic [7:0]    rd_x;
  logic [6:0]    rd_y;
  logic [CW-1:0] rd_colour;
  logic          rd_valid;
  logic          rd_ready;
  logic          oob;
  logic [17:0]   checksum;

  // Drives plots, the readback request and consumer readiness.
  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, start, rd_ready,
    input  done, rd_x, rd_y, rd_colour, rd_valid, oob, checksum
  );

  // The framebuffer reader itself.
  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, start, rd_ready,
    output done, rd_x, rd_y, rd_colour, rd_valid, oob, checksum
  );
endinterface

// File: rtl/plot_framebuffer_reader.sv
// Framebuffer sink for the reduced-VGA plot bus; reads the whole frame back in raster order on start.
// Latency: first rd_valid 2 cycles after start is sampled; 3 cycles minimum per pixel (fetch, load, show).
// Backpressure: rd_ready low holds the presented pixel stable; plots are always accepted. Optional macro CHECKSUM_EN.
module plot_framebuffer_reader #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int CW     = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  plot_framebuffer_reader_if.slave bus
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHOW,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Frame storage: never reset, contents survive rst_n.
  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] ram_q;

  logic          in_range;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  logic [7:0]    cur_x;
  logic [6:0]    cur_y;
  logic          cur_last;

  logic [7:0]    rd_x_q;
  logic [6:0]    rd_y_q;
  logic [CW-1:0] rd_colour_q;
  logic          rd_valid_q;
  logic          done_q;
  logic          oob_q;

  // FSM strobes
  logic scan_start;
  logic rd_en;
  logic load_en;
  logic hs;
  logic done_clr;

  assign in_range = (bus.vga_x <= X_LAST) && (bus.vga_y <= Y_LAST);
  assign wr_addr  = AW'(bus.vga_y) * AW'(WIDTH) + AW'(bus.vga_x);
  assign rd_addr  = AW'(cur_y) * AW'(WIDTH) + AW'(cur_x);
  assign cur_last = (cur_x == X_LAST) && (cur_y == Y_LAST);

  // Plot write port: active in every FSM state, out-of-range plots are dropped.
  always_ff @(posedge clk) begin
    if (bus.vga_plot && in_range) begin
      mem[wr_addr] <= bus.vga_colour;
    end
  end

  // Synchronous read port; a same-cycle write to the same address returns the old data.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      ram_q <= mem[rd_addr];
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oob_q <= 1'b0;
    end else if (bus.vga_plot && !in_range) begin
      oob_q <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_next = state;
    scan_start = 1'b0;
    rd_en      = 1'b0;
    load_en    = 1'b0;
    hs         = 1'b0;
    done_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !done_q) begin
          scan_start = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        rd_en      = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        load_en    = 1'b1;
        state_next = SHOW;
      end
      SHOW: begin
        if (bus.rd_ready) begin
          hs         = 1'b1;
          state_next = cur_last ? DONE : FETCH;
        end
      end
      DONE: begin
        // Start still high keeps us here so a held request cannot trigger a second scan.
        if (!bus.start) begin
          done_clr   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Cursor and presented-pixel registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_x       <= 8'd0;
      cur_y       <= 7'd0;
      rd_x_q      <= 8'd0;
      rd_y_q      <= 7'd0;
      rd_colour_q <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (scan_start) begin
        cur_x <= 8'd0;
        cur_y <= 7'd0;
      end
      if (load_en) begin
        rd_colour_q <= ram_q;
        rd_x_q      <= cur_x;
        rd_y_q      <= cur_y;
        rd_valid_q  <= 1'b1;
      end
      if (hs) begin
        rd_valid_q <= 1'b0;
        if (cur_last) begin
          done_q <= 1'b1;
        end else if (cur_x == X_LAST) begin
          cur_x <= 8'd0;
          cur_y <= cur_y + 7'd1;
        end else begin
          cur_x <= cur_x + 8'd1;
        end
      end
      if (done_clr) begin
        done_q <= 1'b0;
      end
    end
  end

`ifdef CHECKSUM_EN
  logic [17:0] csum_q;

  // Running sum of accepted colours; cleared as each new scan begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= 18'd0;
    end else if (scan_start) begin
      csum_q <= 18'd0;
    end else if (hs) begin
      csum_q <= csum_q + 18'(rd_colour_q);
    end
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = 18'd0;
`endif

  assign bus.rd_x      = rd_x_q;
  assign bus.rd_y      = rd_y_q;
  assign bus.rd_colour = rd_colour_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.done      = done_q;
  assign bus.oob       = oob_q;

endmodule

// File: tb/tb_plot_framebuffer_reader.sv
// Directed bench for plot_framebuffer_reader on a reduced 8x4 frame.
// Plots are applied from a vector table and a reference frame model; readback scans check every pixel.
// Corner sequences: stall, read-during-write, write-ahead, done hold, reset mid-scan.
module tb_plot_framebuffer_reader;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] model [N];

  always #5 clk = ~clk;

  plot_framebuffer_reader_if #(.CW(3)) bus ();

  plot_framebuffer_reader #(.WIDTH(W), .HEIGHT(H), .CW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    bit         wr;
    bit         exp_oob;
  } vec_t;

  vec_t vecs [8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    return {14'd0, y, x, c};
  endfunction

  task automatic chk_reset(input string name);
    chk(name, {bus.done, bus.rd_valid, bus.rd_x, bus.rd_y, bus.rd_colour, bus.oob, bus.checksum}, 64'd0);
  endtask

  task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.vga_x      = x;
    bus.vga_y      = y;
    bus.vga_colour = c;
    bus.vga_plot   = 1'b1;
    tick;
    bus.vga_plot   = 1'b0;
  endtask

  // Full raster scan against the model. stall_idx: hold rd_ready low 10 cycles there and
  // write a later pixel meanwhile. rdw_idx: write that pixel in the cycle it is fetched.
  // abort_idx: reset while that pixel is presented.
  task automatic scan(input int stall_idx, input int rdw_idx, input logic [2:0] rdw_c, input int abort_idx);
    int n;
    logic [7:0]  ex;
    logic [6:0]  ey;
    logic [2:0]  ec;
    logic [2:0]  rdw_old;
    logic [17:0] sum;
    sum          = 18'd0;
    rdw_old      = 3'd0;
    bus.rd_ready = 1'b0;
    bus.start    = 1'b1;
    for (int i = 0; i < N; i++) begin
      ex = 8'(i % W);
      ey = 7'(i / W);
      n  = 0;
      if (i == rdw_idx) begin
        rdw_old  = model[i];
        model[i] = rdw_c;
        plot(ex, ey, rdw_c);
        n = 1;
      end
      while (!bus.rd_valid && n < 8) begin
        tick;
        n++;
      end
      chk("latency", n, (i == 0) ? 3 : 2);
      if (i == abort_idx) begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        tick;
        chk_reset("abort_reset");
        rst_n = 1'b1;
        tick;
        chk_reset("abort_idle");
        return;
      end
      ec = (i == rdw_idx) ? rdw_old : model[i];
      chk("pixel", pix(bus.rd_x, bus.rd_y, bus.rd_colour), pix(ex, ey, ec));
      if (i == stall_idx) begin
        for (int k = 0; k < 10; k++) begin
          if (k == 0) begin
            model[N-3] = 3'd5;
            plot(8'((N - 3) % W), 7'((N - 3) / W), 3'd5);
          end else begin
            tick;
          end
          chk("stall", {bus.rd_valid, pix(bus.rd_x, bus.rd_y, bus.rd_colour)}, {1'b1, pix(ex, ey, ec)});
        end
      end
      sum = sum + 18'(ec);
      bus.rd_ready = 1'b1;
      tick;
      bus.rd_ready = 1'b0;
      chk("valid_drop", bus.rd_valid, 0);
      chk("done", bus.done, (i == N - 1));
    end
`ifdef CHECKSUM_EN
    chk("checksum", bus.checksum, sum);
`else
    chk("checksum", bus.checksum, 0);
`endif
    repeat (4) tick;
    chk("done_hold", {bus.done, bus.rd_valid}, 2'b10);
    bus.start = 1'b0;
    tick;
    chk("done_clear", bus.done, 0);
    tick;
    tick;
    chk("no_restart", bus.rd_valid, 0);
  endtask

  initial begin
    vecs[0] = '{x: 8'd5,   y: 7'd2,   c: 3'd3, wr: 1'b1, exp_oob: 1'b0};
    vecs[1] = '{x: 8'd0,   y: 7'd0,   c: 3'd6, wr: 1'b1, exp_oob: 1'b0};
    vecs[2] = '{x: 8'd7,   y: 7'd3,   c: 3'd1, wr: 1'b1, exp_oob: 1'b0};
    vecs[3] = '{x: 8'd8,   y: 7'd0,   c: 3'd5, wr: 1'b0, exp_oob: 1'b1};
    vecs[4] = '{x: 8'd0,   y: 7'd4,   c: 3'd2, wr: 1'b0, exp_oob: 1'b1};
    vecs[5] = '{x: 8'd2,   y: 7'd1,   c: 3'd4, wr: 1'b1, exp_oob: 1'b1};
    vecs[6] = '{x: 8'd255, y: 7'd127, c: 3'd7, wr: 1'b0, exp_oob: 1'b1};
    vecs[7] = '{x: 8'd7,   y: 7'd0,   c: 3'd2, wr: 1'b1, exp_oob: 1'b1};

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.rd_ready   = 1'b0;
    bus.vga_x      = 8'd0;
    bus.vga_y      = 7'd0;
    bus.vga_colour = 3'd0;
    bus.vga_plot   = 1'b0;
    repeat (3) tick;
    chk_reset("reset");
    rst_n = 1'b1;
    tick;
    chk_reset("idle");

    // Fill every pixel with x[2:0] and read it back; covers the x wrap into the next row.
    for (int i = 0; i < N; i++) begin
      model[i] = 3'(i % W);
      plot(8'(i % W), 7'(i / W), 3'(i % W));
    end
    chk("oob_clean", bus.oob, 0);
    scan(-1, -1, 3'd0, -1);

    // Vector table: in-range plots update the frame, out-of-range ones only raise oob.
    for (int v = 0; v < 8; v++) begin
      plot(vecs[v].x, vecs[v].y, vecs[v].c);
      if (vecs[v].wr) begin
        model[int'(vecs[v].y) * W + int'(vecs[v].x)] = vecs[v].c;
      end
      chk("oob", bus.oob, vecs[v].exp_oob);
    end

    // Stall on pixel (3,0), write-ahead to a later pixel, same-cycle read/write on pixel 12.
    scan(3, 12, 3'd2, -1);
    chk("oob_sticky", bus.oob, 1);

    // All pixels 7, then reset mid-scan and rescan from (0,0) with RAM intact.
    for (int i = 0; i < N; i++) begin
      model[i] = 3'd7;
      plot(8'(i % W), 7'(i / W), 3'd7);
    end
    scan(-1, -1, 3'd0, 20);
    scan(-1, -1, 3'd0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
